// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports and two write ports.
// Write port W takes priority over load port L on an address collision.
// Each register has a busy (reservation) bit. The file can forward same-cycle
// write data to the read ports, and it mirrors one register onto cpu_out
// together with a one-cycle write strobe.
module reg_file_sb #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int OUT_ADDR = (1 << ADDR_W) - 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  ALUResult,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] LA,
    input  logic [WIDTH-1:0]  LD,
    input  logic              LE,
    input  logic [ADDR_W-1:0] RSV_A,
    input  logic              RSV_EN,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic [WIDTH-1:0]  cpu_out,
    output logic              out_strobe
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Address 0 is hard-wired (not writable, never busy) when ZERO_REG is set.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Effective strobes. They are gated by nRST so that an operation that
    // coincides with reset is discarded and does not show up on the bypass path.
    logic w_en, l_en, r_en;
    assign w_en = write_enable && nRST && addr_ok(WA);
    assign l_en = LE && nRST && addr_ok(LA);
    assign r_en = RSV_EN && nRST && addr_ok(RSV_A);

    logic w_hit1, l_hit1, w_hit2, l_hit2;
    assign w_hit1 = w_en && (WA == RA1);
    assign l_hit1 = l_en && (LA == RA1);
    assign w_hit2 = w_en && (WA == RA2);
    assign l_hit2 = l_en && (LA == RA2);

    // Read port 1: stored value, optionally overridden by the winning same-cycle write.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned (no latch).
        RD1   = regs[RA1];
        BUSY1 = busy[RA1];
        if (BYPASS != 0) begin
            if (w_hit1)      RD1 = ALUResult;
            else if (l_hit1) RD1 = LD;
            if (w_hit1 || l_hit1) BUSY1 = 1'b0;
        end
        if (!addr_ok(RA1)) begin
            RD1   = '0;
            BUSY1 = 1'b0;
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        RD2   = regs[RA2];
        BUSY2 = busy[RA2];
        if (BYPASS != 0) begin
            if (w_hit2)      RD2 = ALUResult;
            else if (l_hit2) RD2 = LD;
            if (w_hit2 || l_hit2) BUSY2 = 1'b0;
        end
        if (!addr_ok(RA2)) begin
            RD2   = '0;
            BUSY2 = 1'b0;
        end
    end

    // Register storage. A load to the same address as an ALU write is suppressed, so W wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the storage is cleared on reset because software relies on an all-zero file.
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (l_en && !(w_en && (LA == WA))) regs[LA] <= LD;
            if (w_en)                          regs[WA] <= ALUResult;
        end
    end

    // Next busy state: writes clear the bit, and a reserve applied last sets it again (new owner wins).
    always_comb begin
        // NOTE: blocking assignments in order here; the later assignment deliberately overrides the earlier ones.
        busy_nxt = busy;
        if (w_en) busy_nxt[WA]    = 1'b0;
        if (l_en) busy_nxt[LA]    = 1'b0;
        if (r_en) busy_nxt[RSV_A] = 1'b1;
    end

    // Busy bit register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) busy <= '0;
        else       busy <= busy_nxt;
    end

    logic out_w, out_l;
    assign out_w = w_en && (WA == OUT_A);
    assign out_l = l_en && (LA == OUT_A);

    // Mirror of the output register, plus a strobe in the cycle after every write to it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cpu_out    <= '0;
            out_strobe <= 1'b0;
        end else begin
            if (out_w)      cpu_out <= ALUResult;
            else if (out_l) cpu_out <= LD;
            out_strobe <= out_w || out_l;
        end
    end

endmodule
